// File: rtl/eq_seq_ctrl_pkg.sv
// eq_seq_pkg: shared types and helpers for the sequential equality checker.
//   state_t        - controller states IDLE / RUN / DONE
//   W_DEFAULT      - default operand width
//   pair_idx_w(w)  - width of a pair index for a w-bit operand, max(1, clog2(w/2))
package eq_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int W_DEFAULT = 16;

  function automatic int pair_idx_w(input int w);
    int c;
    c = $clog2(w / 2);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/eq_seq_ctrl_if.sv
// eq_seq_ctrl_if: request/result bundle between a requesting datapath and
// the sequential equality controller.
//   start, a, b              - request side (driven by master)
//   ready, done, aeqb,
//   mism_idx                 - status/result side (driven by slave)
// Modports: master (requester), slave (controller).
import eq_seq_pkg::*;

interface eq_seq_ctrl_if #(
  parameter int W = W_DEFAULT
);
  localparam int IW = pair_idx_w(W);

  logic          start;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          ready;
  logic          done;
  logic          aeqb;
  logic [IW-1:0] mism_idx;

  modport master (
    output start, a, b,
    input  ready, done, aeqb, mism_idx
  );

  modport slave (
    input  start, a, b,
    output ready, done, aeqb, mism_idx
  );
endinterface

// File: rtl/eq_seq_ctrl_eq2_cmp.sv
// eq2_cmp: combinational 2-bit equality slice, shared across all bit pairs.
//   a[1:0], b[1:0] - bit pair under test
//   eq             - 1 when the pairs match
module eq2_cmp (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       eq
);
  assign eq = (a == b);
endmodule

// File: rtl/eq_seq_ctrl.sv
// eq_seq_ctrl: checks two W-bit operands for equality by stepping one
// 2-bit comparator across the word, LSB pair first.
// Ports:
//   clk      - clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - eq_seq_ctrl_if.slave: start/a/b in, ready/done/aeqb/mism_idx out
// Build option:
//   EQ_SEQ_EARLY_EXIT_EN - when defined, RUN ends on the first mismatching pair
//                          (latency k+2); otherwise latency is always P+1.
import eq_seq_pkg::*;

module eq_seq_ctrl #(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset_n,
  eq_seq_ctrl_if.slave bus
);
  localparam int            P    = W / 2;
  localparam int            IW   = pair_idx_w(W);
  localparam logic [IW-1:0] LAST = IW'(P - 1);

`ifdef EQ_SEQ_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  state_t          state;
  logic [IW-1:0]   idx;
  logic [IW-1:0]   mism;
  logic            acc_eq;
  logic            seen;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;
  logic [1:0]      a_pair;
  logic [1:0]      b_pair;
  logic            pair_eq;
  logic            run_exit;
  logic            eq_final;
  logic [IW-1:0]   mism_final;

  // Pair select: idx*2 formed by concatenation so it never overflows.
  always_comb begin
    a_pair = a_reg[{idx, 1'b0} +: 2];
    b_pair = b_reg[{idx, 1'b0} +: 2];
  end

  eq2_cmp u_cmp (
    .a  (a_pair),
    .b  (b_pair),
    .eq (pair_eq)
  );

  // Results fold in the current pair so the last comparison is not lost
  // when the outputs load on the way into DONE.
  always_comb begin
    run_exit   = (idx == LAST) || (EARLY && !pair_eq);
    eq_final   = acc_eq && pair_eq;
    mism_final = seen ? mism : (pair_eq ? '0 : idx);
  end

  // Operand capture: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      a_reg <= bus.a;
      b_reg <= bus.b;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      bus.ready    <= 1'b1;
      bus.done     <= 1'b0;
      bus.aeqb     <= 1'b0;
      bus.mism_idx <= '0;
      idx          <= '0;
      mism         <= '0;
      acc_eq       <= 1'b1;
      seen         <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RUN;
            bus.ready <= 1'b0;
            idx       <= '0;
            mism      <= '0;
            acc_eq    <= 1'b1;
            seen      <= 1'b0;
          end
        end
        RUN: begin
          if (!pair_eq && !seen) begin
            acc_eq <= 1'b0;
            seen   <= 1'b1;
            mism   <= idx;
          end
          if (run_exit) begin
            state        <= DONE;
            bus.done     <= 1'b1;
            bus.aeqb     <= eq_final;
            bus.mism_idx <= mism_final;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          bus.ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
